// File: rtl/rom_access_arbiter_pkg.sv
// Shared definitions for the PW/ID ROM access arbiter: state encoding,
// default ROM geometry and requester indices.
package rom_access_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int unsigned PW_ADDR_W = 5;
  localparam int unsigned PW_DATA_W = 24;
  localparam int unsigned PW_LAT    = 3;

  localparam int unsigned REQ_PW  = 0;
  localparam int unsigned REQ_ID  = 1;
  localparam int unsigned REQ_CFG = 2;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/rom_access_arbiter_rr_pick.sv
// Round-robin picker: first set request bit after 'last', wrapping modulo NREQ.
module rom_access_arbiter_rr_pick #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  int idx;

  // Scan from farthest to nearest so the nearest set bit after 'last' wins.
  always_comb begin
    any    = |req;
    winner = last;
    idx    = 0;
    for (int i = int'(NREQ); i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= int'(NREQ)) begin
        idx = idx - int'(NREQ);
      end
      if (req[idx[IDX_W-1:0]]) begin
        winner = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one fixed-latency synchronous ROM port between NREQ requesters,
// granting round-robin and returning the captured word to the owner.
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = PW_ADDR_W,
  parameter int unsigned DATA_W = PW_DATA_W,
  parameter int unsigned LAT    = PW_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   busy,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_q
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;

  rom_access_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    rom_addr_d  = rom_addr_q;
    rsp_data_d  = rsp_data_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          rom_addr_d        = req_addr[int'(pick_idx)*int'(ADDR_W) +: ADDR_W];
          gnt_d[pick_idx]   = 1'b1;
          owner_d           = pick_idx;
          last_d            = pick_idx;
          cnt_d             = CNT_W'(LAT - 1);
          state_d           = WAIT;
        end
      end
      WAIT: begin
        // Requests are ignored here; the ROM address stays put for the whole access.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_data_d           = rom_q;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= IDX_W'(NREQ - 1);
      owner_q     <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rom_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rom_addr_q  <= rom_addr_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rom_addr  = rom_addr_q;
  assign busy      = (state_q == WAIT);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: LAT=3 instance for the main scenarios,
// LAT=1 instance for the minimum-latency back-to-back case.
module tb_rom_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic [2:0]  req, gnt, rsp_valid;
  logic [14:0] req_addr;
  logic [23:0] rsp_data, rom_q;
  logic [4:0]  rom_addr;
  logic        busy;

  logic [2:0]  req_l1, gnt_l1, rsp_valid_l1;
  logic [14:0] req_addr_l1;
  logic [23:0] rsp_data_l1, rom_q_l1;
  logic [4:0]  rom_addr_l1;
  logic        busy_l1;

  int n_cmp = 0;
  int n_err = 0;

  rom_access_arbiter #(
    .NREQ   (3),
    .ADDR_W (5),
    .DATA_W (24),
    .LAT    (3)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q)
  );

  rom_access_arbiter #(
    .NREQ   (3),
    .ADDR_W (5),
    .DATA_W (24),
    .LAT    (1)
  ) u_dut_l1 (
    .clk       (clk),
    .rst       (rst),
    .req       (req_l1),
    .req_addr  (req_addr_l1),
    .gnt       (gnt_l1),
    .rsp_valid (rsp_valid_l1),
    .rsp_data  (rsp_data_l1),
    .busy      (busy_l1),
    .rom_addr  (rom_addr_l1),
    .rom_q     (rom_q_l1)
  );

  // ROM contents: ROM[5] = 998900, otherwise 123000 + address.
  function automatic logic [23:0] rom_f(input logic [4:0] a);
    if (a == 5'd5) return 24'h998900;
    return 24'h123000 | {19'd0, a};
  endfunction

  // LAT=3 ROM: data valid LAT edges after the address changes, stale before.
  logic [23:0] rom_s1, rom_s2;
  always @(posedge clk) begin
    rom_s1 <= rom_f(rom_addr);
    rom_s2 <= rom_s1;
  end
  assign rom_q    = rom_s2;
  assign rom_q_l1 = rom_f(rom_addr_l1);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full LAT=3 access starting in IDLE: grant, 2 wait cycles, response.
  task automatic access3(input string tag, input logic [2:0] g, input logic [4:0] a,
                         input logic [23:0] d, input bit drop);
    tick();
    check_eq({tag, " gnt"}, 32'(gnt), 32'(g));
    check_eq({tag, " rom_addr"}, 32'(rom_addr), 32'(a));
    check_eq({tag, " busy"}, 32'(busy), 32'd1);
    if (drop) req = req & ~g;
    tick();
    check_eq({tag, " gnt clr"}, 32'(gnt), 32'd0);
    tick();
    check_eq({tag, " no early rsp"}, 32'(rsp_valid), 32'd0);
    tick();
    check_eq({tag, " rsp_valid"}, 32'(rsp_valid), 32'(g));
    check_eq({tag, " rsp_data"}, 32'(rsp_data), 32'(d));
    check_eq({tag, " busy low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst         = 1'b0;
    req         = '0;
    req_addr    = '0;
    req_l1      = '0;
    req_addr_l1 = '0;
    repeat (3) tick();

    // 1: reset state, then single access to ROM[5]
    check_eq("rst gnt", 32'(gnt), 32'd0);
    check_eq("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst rom_addr", 32'(rom_addr), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    rst = 1'b1;
    req = 3'b001;
    req_addr[4:0] = 5'd5;
    access3("t1", 3'b001, 5'd5, 24'h998900, 1'b1);
    tick();
    check_eq("t1 rsp_valid clr", 32'(rsp_valid), 32'd0);
    check_eq("t1 rsp_data held", 32'(rsp_data), 32'h998900);
    check_eq("t1 busy after", 32'(busy), 32'd0);

    // 2: all three held through reset, round-robin from last=2
    rst = 1'b0;
    req = 3'b111;
    req_addr = {5'd3, 5'd2, 5'd1};
    tick();
    rst = 1'b1;
    access3("t2 r0", 3'b001, 5'd1, 24'h123001, 1'b1);
    access3("t2 r1", 3'b010, 5'd2, 24'h123002, 1'b1);
    access3("t2 r2", 3'b100, 5'd3, 24'h123003, 1'b1);

    // 3: req0 and req2 held continuously alternate
    req = 3'b101;
    req_addr = {5'd9, 5'd4, 5'd7};
    access3("t3 a", 3'b001, 5'd7, 24'h123007, 1'b0);
    access3("t3 b", 3'b100, 5'd9, 24'h123009, 1'b0);
    access3("t3 c", 3'b001, 5'd7, 24'h123007, 1'b0);
    access3("t3 d", 3'b100, 5'd9, 24'h123009, 1'b0);
    req = 3'b000;

    // 4: reset in WAIT with cnt=1 discards the access
    req = 3'b010;
    req_addr[9:5] = 5'd4;
    tick();
    check_eq("t4 gnt", 32'(gnt), 32'b010);
    req = 3'b000;
    tick();
    rst = 1'b0;
    tick();
    check_eq("t4 rst gnt", 32'(gnt), 32'd0);
    check_eq("t4 rst rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("t4 rst rsp_data", 32'(rsp_data), 32'd0);
    check_eq("t4 rst rom_addr", 32'(rom_addr), 32'd0);
    check_eq("t4 rst busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();
    check_eq("t4 no late rsp", 32'(rsp_valid), 32'd0);
    req = 3'b110;
    req_addr = {5'd8, 5'd4, 5'd0};
    access3("t4 r1", 3'b010, 5'd4, 24'h123004, 1'b1);
    access3("t4 r2", 3'b100, 5'd8, 24'h123008, 1'b1);

    // 5: request raised during WAIT and dropped before IDLE is never served
    req = 3'b001;
    req_addr = {5'd8, 5'd6, 5'd10};
    tick();
    check_eq("t5 gnt", 32'(gnt), 32'b001);
    check_eq("t5 rom_addr", 32'(rom_addr), 32'd10);
    req = 3'b010;
    tick();
    check_eq("t5 wait gnt a", 32'(gnt), 32'd0);
    check_eq("t5 wait addr a", 32'(rom_addr), 32'd10);
    tick();
    check_eq("t5 wait gnt b", 32'(gnt), 32'd0);
    check_eq("t5 wait addr b", 32'(rom_addr), 32'd10);
    req = 3'b000;
    tick();
    check_eq("t5 rsp_valid", 32'(rsp_valid), 32'b001);
    check_eq("t5 rsp_data", 32'(rsp_data), 32'h12300a);
    tick();
    check_eq("t5 no gnt r1", 32'(gnt), 32'd0);
    check_eq("t5 idle", 32'(busy), 32'd0);

    // 6: LAT=1 instance, back-to-back every 2 cycles
    req_l1 = 3'b011;
    req_addr_l1 = {5'd0, 5'd3, 5'd2};
    tick();
    check_eq("t6 gnt0", 32'(gnt_l1), 32'b001);
    check_eq("t6 addr0", 32'(rom_addr_l1), 32'd2);
    check_eq("t6 busy0", 32'(busy_l1), 32'd1);
    req_l1 = 3'b010;
    tick();
    check_eq("t6 rsp0", 32'(rsp_valid_l1), 32'b001);
    check_eq("t6 data0", 32'(rsp_data_l1), 32'h123002);
    check_eq("t6 busy idle", 32'(busy_l1), 32'd0);
    tick();
    check_eq("t6 gnt1", 32'(gnt_l1), 32'b010);
    check_eq("t6 addr1", 32'(rom_addr_l1), 32'd3);
    req_l1 = 3'b000;
    tick();
    check_eq("t6 rsp1", 32'(rsp_valid_l1), 32'b010);
    check_eq("t6 data1", 32'(rsp_data_l1), 32'h123003);
    tick();
    check_eq("t6 quiet", 32'(gnt_l1 | rsp_valid_l1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Shares one synchronous, fixed-latency ROM port between several requesters: the password checker, the user-ID lookup and the score/config fetch. Requesters present an address and hold a request. The block grants them in round-robin order, drives the ROM address, and waits the ROM latency. It then returns the captured word with a one-hot valid pulse to the owner. It sits between the authentication and game controllers and the PW/ID ROM instance.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 5, ROM address width
- DATA_W, 24, ROM word width (six 4-bit digits)
- LAT, 3, edges from rom_addr update to valid rom_q (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester request level, held until gnt
- req_addr  in  NREQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]; stable while req[i]=1
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: rsp_data belongs to that requester
- rsp_data  out  DATA_W  captured ROM word; held until next capture
- busy  out  1  high while an access is in flight (state != IDLE)
- rom_addr  out  ADDR_W  registered ROM address
- rom_q  in  DATA_W  ROM read data

## Operation
- States: IDLE, WAIT.
- Reset (rst=0 at an edge): state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, rom_addr=0, busy=0, cnt=0, last=NREQ-1, owner=0. This takes priority over every other action; an in-flight access is discarded without a response.
- IDLE, when any req bit is set, at edge E0:
  - winner = first set req bit scanning last+1, last+2, … modulo NREQ.
  - rom_addr <= req_addr[winner]; gnt[winner] <= 1; owner <= winner; last <= winner; cnt <= LAT-1; state <= WAIT.
- IDLE with no req: outputs hold; gnt and rsp_valid are 0.
- WAIT:
  - gnt <= 0; rom_addr holds; req inputs are ignored (no queuing, no grant).
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0: rsp_data <= rom_q; rsp_valid[owner] <= 1; state <= IDLE.
- rsp_valid clears at the next edge unconditionally.
- A requester that drops req before gnt is simply not served. A requester still holding req after its gnt is treated as a new request in round-robin order. Requesters drop req in the gnt cycle to avoid a duplicate access.
- The owner's request bit is excluded only by pointer order: if it is the sole requester, it is granted again.
- cnt width is 4 bits. LAT=1 loads cnt=0 and captures at the first WAIT edge.

## Timing
- The grant decision is combinational on req and last; all outputs are registered.
- gnt and the new rom_addr are visible in cycle E0+1.
- rom_q is sampled at edge E0+LAT.
- rsp_valid and rsp_data are visible in cycle E0+LAT+1, i.e. LAT cycles after gnt.
- The earliest next grant is at edge E0+LAT+1, the same cycle rsp_valid is high. Peak throughput is one access per LAT+1 cycles (4 at default).
- Simultaneous requests resolve in one cycle by round-robin. No requester waits more than NREQ accesses.
- busy is high from E0+1 through E0+LAT and low in the rsp_valid cycle.

## Structure
- Shared package holds:
  - the state encoding constants IDLE/WAIT;
  - default ADDR_W=5, DATA_W=24, LAT=3 for the PW ROM;
  - requester index constants: REQ_PW=0, REQ_ID=1, REQ_CFG=2.
- One sub-module: rr_pick (combinational).
  - Inputs: req, last. Outputs: any, winner index.
  - Rotate, find first set, rotate back.
- The FSM, counter and output registers stay in rom_access_arbiter.

## Test plan
1. Reset, then req=3'b001 with addr0=5, where ROM[5]=24'h998900. Required: gnt=001 in cycle 1, rom_addr=5, rsp_valid=001 three cycles later with rsp_data=24'h998900, busy low thereafter.
2. req=3'b111 held from reset, each requester dropping on its gnt, addrs 1/2/3. Required: grants in order 0,1,2, spaced 4 cycles apart; each rsp_data matches ROM[1], ROM[2], ROM[3].
3. req0 and req2 held continuously. Required: grants alternate 0,2,0,2; req1 is never granted.
4. rst=0 during WAIT with cnt=1. Required: no rsp_valid pulse, all outputs 0. A following req1 is granted first by scan order from last=2 and served normally.
5. req1 raised while busy, then req1 dropped before IDLE. Required: no gnt to requester 1, and rom_addr unchanged during WAIT.
6. Build with LAT=1. Required: rsp_valid one cycle after gnt, and back-to-back accesses every 2 cycles.
